load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_if.sv | 27 ++
 rtl/load_unit.sv | 114 +++++++++++
 tb/tb_load_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_unit_if.sv
// Bus bundle for the load unit: request channel, SRAM read port and writeback channel.
// The slave modport is the load unit itself; master is the surrounding core/SRAM.
interface load_unit_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_type;
  logic [31:0] Aluout;
  logic [4:0]  ld_dst;
  logic        data_sram_en;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        addr_err;

  modport slave (
    input  ld_valid, ld_type, Aluout, ld_dst, data_sram_rdata, wb_ready,
    output ld_ready, data_sram_en, data_sram_addr, wb_valid, wb_data, wb_dst, addr_err
  );

  modport master (
    output ld_valid, ld_type, Aluout, ld_dst, data_sram_rdata, wb_ready,
    input  ld_ready, data_sram_en, data_sram_addr, wb_valid, wb_data, wb_dst, addr_err
  );
endinterface

// File: rtl/load_unit.sv
// Single-outstanding load unit: issues one SRAM read per request, extracts and
// extends the addressed byte/half/word, and holds the result until consumed.
module load_unit (
  input  logic         clk,
  input  logic         reset,
  load_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [28:0] addr_q;
  logic [2:0]  type_q;
  logic [4:0]  dst_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        accept;
  logic        mis;

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    logic res;
    res = 1'b0;
    case (t)
      3'b000, 3'b001: res = 1'b0;
      3'b010, 3'b011: res = a[0];
      default:        res = (a != 2'b00);
    endcase
    return res;
  endfunction

  // Undefined type encodings fall through to the full-word case.
  function automatic logic [31:0] extend_load(input logic [2:0]  t,
                                              input logic [1:0]  a,
                                              input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    case (a)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (t)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {24'd0, b};
      3'b010:  res = {{16{h[15]}}, h};
      3'b011:  res = {16'd0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign accept = bus.ld_valid && (state == IDLE);
  assign mis    = misaligned(bus.ld_type, bus.Aluout[1:0]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.ld_ready     = 1'b0;
    bus.data_sram_en = 1'b0;
    bus.wb_valid     = 1'b0;
    case (state)
      IDLE: begin
        bus.ld_ready = 1'b1;
        if (accept) state_nxt = mis ? DONE : REQ;
      end
      REQ: begin
        bus.data_sram_en = 1'b1;
        state_nxt        = RESP;
      end
      RESP: state_nxt = DONE;
      DONE: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on accept; result capture at the end of the RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      type_q <= '0;
      dst_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.Aluout[28:0];
        type_q <= bus.ld_type;
        dst_q  <= bus.ld_dst;
        data_q <= '0;
        err_q  <= mis;
      end
      if (state == RESP) begin
        data_q <= extend_load(type_q, addr_q[1:0], bus.data_sram_rdata);
        err_q  <= 1'b0;
      end
    end
  end

  assign bus.data_sram_addr = {3'b000, addr_q[28:2], 2'b00};
  assign bus.wb_data        = data_q;
  assign bus.wb_dst         = dst_q;
  assign bus.addr_err       = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: directed vector table, hand sequences for stall and
// mid-load reset, and randomized loads against a behavioural model.
module tb_load_unit;

  logic clk;
  logic reset;
  load_unit_if bus ();

  load_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [31:0] sram_word;

  // SRAM: word appears on rdata the cycle after a read enable.
  always @(posedge clk) begin
    if (bus.data_sram_en) bus.data_sram_rdata <= sram_word;
    else                  bus.data_sram_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [2:0]  ld_type;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: access size from type, shift the word down to the
  // addressed byte, mask to size, and sign-extend by subtraction.
  function automatic logic [31:0] model_data(input logic [2:0] t, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned size;
    logic [31:0] v;
    bit sgn;
    size = (t <= 3'd1) ? 1 : (t <= 3'd3) ? 2 : 4;
    sgn  = (t == 3'd0) || (t == 3'd2);
    if (addr % size != 0) return 32'd0;
    v = word >> (8 * (addr % 4));
    if (size == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic model_err(input logic [2:0] t, input logic [31:0] addr);
    int unsigned size;
    size = (t <= 3'd1) ? 1 : (t <= 3'd3) ? 2 : 4;
    return (addr % size) != 0;
  endfunction

  // Issue one load and follow it to wb_valid; leaves the result pending.
  task automatic do_load(input logic [2:0] t, input logic [31:0] addr, input logic [4:0] dst,
                         input logic [31:0] word, input logic [31:0] exp_data, input logic exp_err);
    int k;
    int en_cnt;
    int en_at;
    bit seen;
    int waited;
    @(negedge clk);
    waited = 0;
    while (!bus.ld_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ld_ready_before_req", {31'd0, bus.ld_ready}, 32'd1);
    sram_word   = word;
    bus.ld_valid = 1'b1;
    bus.ld_type  = t;
    bus.Aluout   = addr;
    bus.ld_dst   = dst;
    @(posedge clk);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.Aluout   = 32'h5555_5555;
    bus.ld_type  = 3'b000;
    en_cnt = 0;
    en_at  = 0;
    seen   = 0;
    k      = 1;
    while (k <= 8) begin
      if (bus.data_sram_en) begin
        en_cnt++;
        en_at = k;
        check("sram_addr", bus.data_sram_addr, (addr & 32'h1fff_ffff) & ~32'd3);
      end
      if (bus.wb_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      k++;
    end
    check("wb_valid_seen", {31'd0, seen}, 32'd1);
    check("latency", k, exp_err ? 32'd1 : 32'd3);
    check("en_count", en_cnt, exp_err ? 32'd0 : 32'd1);
    if (!exp_err) check("en_cycle", en_at, 32'd1);
    check("wb_data", bus.wb_data, exp_data);
    check("addr_err", {31'd0, bus.addr_err}, {31'd0, exp_err});
    check("wb_dst", {27'd0, bus.wb_dst}, {27'd0, dst});
  endtask

  task automatic finish_wb();
    @(negedge clk);
    check("ld_ready_in_done", {31'd0, bus.ld_ready}, 32'd0);
    bus.wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wb_ready = 1'b0;
    check("idle_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [31:0] held;
    bit          stray;
    n_cmp = 0;
    n_bad = 0;
    sram_word    = 32'd0;
    reset        = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_type  = 3'b000;
    bus.Aluout   = 32'd0;
    bus.ld_dst   = 5'd0;
    bus.wb_ready = 1'b0;

    vecs.push_back('{3'b000, 32'h0000_0003, 32'h8011_2233, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{3'b011, 32'h0000_0002, 32'h8001_ABCD, 32'h0000_8001, 1'b0});
    vecs.push_back('{3'b010, 32'h0000_0002, 32'h8001_ABCD, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{3'b100, 32'hA000_0004, 32'h1234_5678, 32'h1234_5678, 1'b0});
    vecs.push_back('{3'b100, 32'h0000_0006, 32'h1234_5678, 32'h0000_0000, 1'b1});
    vecs.push_back('{3'b001, 32'h0000_0001, 32'h0000_A500, 32'h0000_00A5, 1'b0});
    vecs.push_back('{3'b000, 32'h0000_0000, 32'h0000_007F, 32'h0000_007F, 1'b0});
    vecs.push_back('{3'b000, 32'h0000_0002, 32'h00FF_0000, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{3'b011, 32'h0000_0000, 32'h1234_FFFE, 32'h0000_FFFE, 1'b0});
    vecs.push_back('{3'b111, 32'h0000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{3'b101, 32'h0000_0002, 32'hCAFE_F00D, 32'h0000_0000, 1'b1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("rst_en", {31'd0, bus.data_sram_en}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_wb_dst", {27'd0, bus.wb_dst}, 32'd0);
    check("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
    check("rst_sram_addr", bus.data_sram_addr, 32'd0);

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      do_load(vecs[i].ld_type, vecs[i].addr, 5'(i + 1), vecs[i].rdata,
              vecs[i].exp_data, vecs[i].exp_err);
      finish_wb();
    end

    // Stall in DONE for 5 cycles while a stray request is presented
    do_load(3'b000, 32'h0000_0003, 5'd9, 32'h8011_2233, 32'hFFFF_FF80, 1'b0);
    held  = bus.wb_data;
    stray = 0;
    bus.ld_valid = 1'b1;
    bus.ld_type  = 3'b100;
    bus.Aluout   = 32'h0000_0100;
    bus.ld_dst   = 5'd30;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.data_sram_en) stray = 1;
      check("stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      check("stall_wb_data", bus.wb_data, held);
      check("stall_wb_dst", {27'd0, bus.wb_dst}, 32'd9);
      check("stall_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    end
    check("stall_no_sram", {31'd0, stray}, 32'd0);
    bus.ld_valid = 1'b0;
    finish_wb();

    // Reset asserted during RESP abandons the load
    @(negedge clk);
    sram_word    = 32'h7777_7777;
    bus.ld_valid = 1'b1;
    bus.ld_type  = 3'b100;
    bus.Aluout   = 32'h0000_0010;
    bus.ld_dst   = 5'd4;
    @(posedge clk);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    check("rr_en_in_req", {31'd0, bus.data_sram_en}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rr_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("rr_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rr_wb_data", bus.wb_data, 32'd0);
    check("rr_wb_dst", {27'd0, bus.wb_dst}, 32'd0);
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.wb_valid || bus.data_sram_en) stray = 1;
    end
    check("rr_no_result", {31'd0, stray}, 32'd0);

    // Randomized loads against the model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  t;
      logic [31:0] a;
      logic [31:0] w;
      logic [4:0]  d;
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      w = $urandom;
      d = 5'($urandom_range(0, 31));
      do_load(t, a, d, w, model_data(t, a, w), model_err(t, a));
      finish_wb();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
